// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller for the five-stage CPU.
// Detects register hazards that forwarding cannot cover and mult/div busy
// hazards. On either kind it freezes PC and IF/ID and injects a bubble into
// ID/EX. It also counts the stall cycles for performance monitoring.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        RA1_ID,
  input  logic [4:0]        RA2_ID,
  input  logic [1:0]        Tuse_rs_ID,
  input  logic [1:0]        Tuse_rt_ID,
  input  logic              md_use_ID,
  input  logic [4:0]        WA_EX,
  input  logic              GRFWE_EX,
  input  logic [1:0]        Tnew_EX,
  input  logic [4:0]        WA_MEM,
  input  logic              GRFWE_MEM,
  input  logic [1:0]        Tnew_MEM,
  input  logic              md_start_EX,
  input  logic              md_div_EX,
  output logic              PC_en,
  output logic              IF_ID_en,
  output logic              ID_EX_flush,
  output logic              md_busy,
  output logic              stall,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic [CNT_W-1:0]  md_cnt_q;
  logic [CNT_W-1:0]  md_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  assign md_busy = (md_cnt_q != '0);

  // A source register stalls when a producer in EX or MEM writes it later than ID needs it; $0 never stalls
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    stall_md = 1'b0;
    if (RA1_ID != 5'd0) begin
      stall_rs = (GRFWE_EX  && (WA_EX  == RA1_ID) && (Tuse_rs_ID < Tnew_EX)) ||
                 (GRFWE_MEM && (WA_MEM == RA1_ID) && (Tuse_rs_ID < Tnew_MEM));
    end
    if (RA2_ID != 5'd0) begin
      stall_rt = (GRFWE_EX  && (WA_EX  == RA2_ID) && (Tuse_rt_ID < Tnew_EX)) ||
                 (GRFWE_MEM && (WA_MEM == RA2_ID) && (Tuse_rt_ID < Tnew_MEM));
    end
    stall_md = md_use_ID && (md_busy || md_start_EX);
  end

  // Stall drives the pipeline enables directly, so it adds no latency
  always_comb begin
    stall       = stall_rs | stall_rt | stall_md;
    PC_en       = ~stall;
    IF_ID_en    = ~stall;
    ID_EX_flush = stall;
  end

  // Busy countdown: loads only when idle, so a start arriving while busy is ignored
  always_comb begin
    md_cnt_d = md_cnt_q;
    if ((md_cnt_q == '0) && md_start_EX) begin
      md_cnt_d = md_div_EX ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  // Stall cycle counter saturates at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  // State registers with synchronous reset; reset also aborts any countdown in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl. It runs directed scenarios and
// then randomized traffic. The reference model tracks mult/div busy time as
// an absolute "busy until cycle" value and the stall count as a plain integer.
module tb_hazard_stall_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int PERF_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        RA1_ID, RA2_ID, WA_EX, WA_MEM;
  logic [1:0]        Tuse_rs_ID, Tuse_rt_ID, Tnew_EX, Tnew_MEM;
  logic              md_use_ID, GRFWE_EX, GRFWE_MEM, md_start_EX, md_div_EX;
  logic              PC_en, IF_ID_en, ID_EX_flush, md_busy, stall;
  logic [PERF_W-1:0] stall_cnt;

  int     checkCount = 0;
  int     errorCount = 0;
  int     cycleNum   = 0;
  int     busyUntil  = -1;
  longint stallTotal = 0;
  longint perfMax    = (longint'(1) << PERF_W) - 1;

  hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .RA1_ID(RA1_ID), .RA2_ID(RA2_ID), .Tuse_rs_ID(Tuse_rs_ID), .Tuse_rt_ID(Tuse_rt_ID),
    .md_use_ID(md_use_ID), .WA_EX(WA_EX), .GRFWE_EX(GRFWE_EX), .Tnew_EX(Tnew_EX),
    .WA_MEM(WA_MEM), .GRFWE_MEM(GRFWE_MEM), .Tnew_MEM(Tnew_MEM),
    .md_start_EX(md_start_EX), .md_div_EX(md_div_EX),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_flush(ID_EX_flush),
    .md_busy(md_busy), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Compares one observed value against its expected value and counts the check
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  // A source is blocked if some in-flight writer of it will produce its value later than ID needs it
  function automatic bit sourceBlocked(input logic [4:0] ra, input logic [1:0] tuse);
    int readyIn [2];
    bit writes  [2];
    logic [4:0] dest [2];
    writes[0] = GRFWE_EX;  dest[0] = WA_EX;  readyIn[0] = int'(Tnew_EX);
    writes[1] = GRFWE_MEM; dest[1] = WA_MEM; readyIn[1] = int'(Tnew_MEM);
    if (ra == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (writes[k] && dest[k] == ra && readyIn[k] > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  // Drives nothing itself: checks the current cycle against the model, then advances one clock edge
  task automatic applyStimulus();
    bit expBusy, expStall;
    @(negedge clk);
    expBusy = (cycleNum <= busyUntil);
    checkOutput("md_busy", 32'(md_busy), 32'(expBusy));
    checkOutput("stall_cnt", stall_cnt, stallTotal[31:0]);
    expStall = sourceBlocked(RA1_ID, Tuse_rs_ID) || sourceBlocked(RA2_ID, Tuse_rt_ID) ||
               (md_use_ID && (expBusy || md_start_EX));
    if (!reset) begin
      checkOutput("stall", 32'(stall), 32'(expStall));
      checkOutput("PC_en", 32'(PC_en), 32'(!expStall));
      checkOutput("IF_ID_en", 32'(IF_ID_en), 32'(!expStall));
      checkOutput("ID_EX_flush", 32'(ID_EX_flush), 32'(expStall));
    end
    @(posedge clk);
    if (reset) begin
      busyUntil  = cycleNum;
      stallTotal = 0;
    end else begin
      if (!expBusy && md_start_EX) busyUntil = cycleNum + (md_div_EX ? DIV_CYC : MULT_CYC);
      if (expStall && stallTotal < perfMax) stallTotal++;
    end
    cycleNum++;
    #1;
  endtask

  task automatic setIdle();
    reset = 1'b0;
    RA1_ID = 5'd0; RA2_ID = 5'd0; Tuse_rs_ID = 2'd3; Tuse_rt_ID = 2'd3; md_use_ID = 1'b0;
    WA_EX = 5'd0; GRFWE_EX = 1'b0; Tnew_EX = 2'd0;
    WA_MEM = 5'd0; GRFWE_MEM = 1'b0; Tnew_MEM = 2'd0;
    md_start_EX = 1'b0; md_div_EX = 1'b0;
  endtask

  task automatic doReset();
    setIdle();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    setIdle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    busyUntil = cycleNum - 1;
    reset = 1'b0;

    // Reset state with quiet inputs
    applyStimulus();

    // Load-use, then bubble in EX and lw in MEM
    setIdle();
    WA_EX = 5'd5; GRFWE_EX = 1'b1; Tnew_EX = 2'd2; RA1_ID = 5'd5; Tuse_rs_ID = 2'd1;
    applyStimulus();
    setIdle();
    WA_MEM = 5'd5; GRFWE_MEM = 1'b1; Tnew_MEM = 2'd1; RA1_ID = 5'd5; Tuse_rs_ID = 2'd1;
    applyStimulus();
    checkOutput("loadUseCount", stall_cnt, 32'd1);

    // $0 and never-used source
    setIdle();
    WA_EX = 5'd0; GRFWE_EX = 1'b1; Tnew_EX = 2'd2; RA1_ID = 5'd0; Tuse_rs_ID = 2'd1;
    applyStimulus();
    WA_EX = 5'd5; RA1_ID = 5'd5; Tuse_rs_ID = 2'd3; Tnew_EX = 2'd3;
    applyStimulus();

    // Forwardable vs not for rt
    setIdle();
    WA_EX = 5'd8; GRFWE_EX = 1'b1; Tnew_EX = 2'd1; RA2_ID = 5'd8; Tuse_rt_ID = 2'd0;
    applyStimulus();
    Tuse_rt_ID = 2'd1;
    applyStimulus();

    // Mult followed by mfhi: six stall cycles
    doReset();
    setIdle();
    md_use_ID = 1'b1; md_start_EX = 1'b1;
    applyStimulus();
    md_start_EX = 1'b0;
    repeat (MULT_CYC) applyStimulus();
    checkOutput("multStallCount", stall_cnt, 32'(MULT_CYC + 1));
    applyStimulus();
    checkOutput("multReleased", 32'(stall), 32'd0);

    // Div with an illegal second start while busy
    setIdle();
    md_start_EX = 1'b1; md_div_EX = 1'b1;
    applyStimulus();
    setIdle();
    repeat (2) applyStimulus();
    md_start_EX = 1'b1;
    applyStimulus();
    setIdle();
    repeat (DIV_CYC - 3) applyStimulus();
    checkOutput("divBusyEnd", 32'(md_busy), 32'd0);

    // Reset in the middle of a div
    setIdle();
    md_start_EX = 1'b1; md_div_EX = 1'b1;
    applyStimulus();
    setIdle();
    md_use_ID = 1'b1;
    repeat (3) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midDivBusy", 32'(md_busy), 32'd0);
    checkOutput("midDivStall", 32'(stall), 32'd0);
    applyStimulus();

    // Randomized traffic with small register ranges to provoke matches
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      RA1_ID      = 5'($urandom_range(0, 3));
      RA2_ID      = 5'($urandom_range(0, 3));
      Tuse_rs_ID  = 2'($urandom_range(0, 3));
      Tuse_rt_ID  = 2'($urandom_range(0, 3));
      md_use_ID   = ($urandom_range(0, 3) == 0);
      WA_EX       = 5'($urandom_range(0, 3));
      GRFWE_EX    = 1'($urandom_range(0, 1));
      Tnew_EX     = 2'($urandom_range(0, 3));
      WA_MEM      = 5'($urandom_range(0, 3));
      GRFWE_MEM   = 1'($urandom_range(0, 1));
      Tnew_MEM    = 2'($urandom_range(0, 3));
      md_start_EX = ($urandom_range(0, 7) == 0);
      md_div_EX   = 1'($urandom_range(0, 1));
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller for the five-stage CPU. Sits beside the IF/ID and ID/EX pipeline registers.
- Compares Tuse of the instruction in ID against Tnew and WA of the instructions in EX and MEM. On a hazard that forwarding cannot resolve, it freezes PC and IF/ID and injects a bubble into ID/EX.
- Sequences the multi-cycle mult/div unit with an internal busy countdown. Any HI/LO-dependent instruction in ID stalls until that countdown expires.

Parameters:
- MULT_CYC, 5, number of busy cycles after a mult/multu starts in EX.
- DIV_CYC, 10, number of busy cycles after a div/divu starts in EX.
- CNT_W, 4, width of the busy counter; must hold DIV_CYC.
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- RA1_ID  in  5  rs address of the instruction in ID.
- RA2_ID  in  5  rt address of the instruction in ID.
- Tuse_rs_ID  in  2  cycles until rs is needed (3 = never used).
- Tuse_rt_ID  in  2  cycles until rt is needed (3 = never used).
- md_use_ID  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo.
- WA_EX  in  5  destination register of the instruction in EX.
- GRFWE_EX  in  1  instruction in EX writes the GRF.
- Tnew_EX  in  2  cycles until the EX result is available.
- WA_MEM  in  5  destination register of the instruction in MEM.
- GRFWE_MEM  in  1  instruction in MEM writes the GRF.
- Tnew_MEM  in  2  cycles until the MEM result is available.
- md_start_EX  in  1  a mult/div is in EX this cycle.
- md_div_EX  in  1  1 = div-class, 0 = mult-class; qualified by md_start_EX.
- PC_en  out  1  PC write enable.
- IF_ID_en  out  1  IF/ID register enable.
- ID_EX_flush  out  1  clear the ID/EX register to a nop on the next edge.
- md_busy  out  1  mult/div unit is busy.
- stall  out  1  raw stall indication.
- stall_cnt  out  PERF_W  number of stall cycles since reset.

Behaviour:
- Register hazard (combinational):
  - stall_rs = RA1_ID!=0 && ((GRFWE_EX && WA_EX==RA1_ID && Tuse_rs_ID<Tnew_EX) || (GRFWE_MEM && WA_MEM==RA1_ID && Tuse_rs_ID<Tnew_MEM)).
  - stall_rt is the same expression using RA2_ID and Tuse_rt_ID.
  - Register $0 never stalls.
  - Tuse=3 never stalls, because Tnew is at most 3.
- MD hazard (combinational): stall_md = md_use_ID && (md_busy || md_start_EX).
- stall = stall_rs | stall_rt | stall_md. Outputs derived from it:
  - PC_en = ~stall.
  - IF_ID_en = ~stall.
  - ID_EX_flush = stall.
  - These depend on the current inputs and state only, so there is no added latency.
- Busy counter md_cnt (CNT_W bits, registered):
  - If md_cnt==0 and md_start_EX: load DIV_CYC when md_div_EX, otherwise MULT_CYC.
  - Else if md_cnt!=0: decrement by 1.
  - md_start_EX while md_cnt!=0 is illegal, because the stall prevents it. If it occurs anyway, it is ignored and the count keeps decrementing.
  - md_busy = (md_cnt!=0), registered state. md_busy rises the cycle after start and stays high for exactly MULT_CYC or DIV_CYC cycles.
  - Including md_start_EX in stall_md covers the start cycle itself. An mfhi directly after a mult therefore stalls MULT_CYC+1 cycles in total.
- stall_cnt increments by 1 on every edge where stall=1 and reset=0. It saturates at all-ones and does not wrap.
- Reset (at a clk edge with reset=1):
  - md_cnt=0 and stall_cnt=0.
  - Valid from the cycle after that edge: md_busy=0, stall=0, PC_en=1, IF_ID_en=1, ID_EX_flush=0, given hazard-free inputs.
  - Reset asserted mid mult/div aborts the countdown immediately.
  - While reset is high the pipeline registers are themselves reset, so the combinational outputs are don't-care.
- Simultaneous register and MD hazard: one stall, counted once per cycle.
- A flushed bubble arrives in EX with GRFWE=0 and Tnew=0, which releases the stall on the following cycle when the hazard is resolved.

Test Plan:
- Load-use: EX holds lw with WA_EX=5, GRFWE_EX=1, Tnew_EX=2; ID has RA1_ID=5, Tuse_rs_ID=1 -> stall=1, PC_en=0, ID_EX_flush=1. Next cycle MEM has Tnew_MEM=1 and EX holds a bubble -> stall=0. stall_cnt=1.
- $0 and no-use: same as above but RA1_ID=0, then RA1_ID=5 with Tuse_rs_ID=3 -> stall=0 in both cases.
- Forwardable case: EX addu with WA_EX=8, Tnew_EX=1; ID beq with RA2_ID=8, Tuse_rt_ID=0 -> stall=1. Change to Tuse_rt_ID=1 -> stall=0.
- Mult then mfhi:
  - md_start_EX=1, md_div_EX=0 at cycle t, with md_use_ID=1 held -> stall=1 at cycles t..t+5 and md_busy=1 at cycles t+1..t+5.
  - stall=0 at t+6; stall_cnt=6.
- Div while busy: div started (DIV_CYC=10); a second md_start_EX at cycle t+3 -> ignored; md_busy falls after exactly 10 cycles from the first start.
- Reset mid-div: assert reset at cycle t+4 of a div -> after that edge md_busy=0, stall_cnt=0, stall=0 with md_use_ID=1 and no md_start_EX.
